// File: rtl/seq_mag_comparator_pkg.sv
// -----------------------------------------------------------------------------
// seq_cmp_pkg
// Shared types and helpers for the sequential magnitude comparator.
//   state_t      : comparator FSM states (IDLE, RUN)
//   CMP_*        : 2-bit slice verdict encoding
//   num_chunks() : ceiling of width/chunk, the number of slices per operand
// -----------------------------------------------------------------------------
package seq_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/seq_mag_comparator_cmp_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned comparator for one CHUNK-bit slice.
// Ports:
//   a, b    : slice operands (unsigned)
//   verdict : CMP_GT / CMP_LT / CMP_EQ
// -----------------------------------------------------------------------------
module cmp_chunk
    import seq_cmp_pkg::*;
#(
    parameter int CHUNK = 3
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [1:0]       verdict
);

    always_comb begin
        verdict = CMP_EQ;
        if (a > b) begin
            verdict = CMP_GT;
        end else if (a < b) begin
            verdict = CMP_LT;
        end
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// -----------------------------------------------------------------------------
// seq_mag_comparator
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands one
// CHUNK-bit slice per clock, most significant slice first, in unsigned or
// two's-complement mode, with a start/busy/done handshake.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : request, sampled only while busy = 0
//   signed_mode, A, B  : operands and mode, sampled with start
//   busy               : compare in progress
//   done               : one-cycle pulse when a new result is valid
//   A_gt_B/A_eq_B/A_lt_B : one-hot result, held until the next done
//
// Build option SEQ_CMP_EARLY_EXIT_EN:
//   defined   - finish on the first differing slice (latency 1..NUM_CHUNKS)
//   undefined - always walk every slice (latency fixed at NUM_CHUNKS); the
//               first differing slice's verdict is kept in a sticky register
// -----------------------------------------------------------------------------
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int EXT_W      = NUM_CHUNKS * CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CHUNKS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [EXT_W-1:0] a_ext;
    logic [EXT_W-1:0] b_ext;
    logic [EXT_W-1:0] a_op;
    logic [EXT_W-1:0] b_op;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [1:0]       slice_verdict;
    logic [1:0]       final_verdict;
    logic             finish;
    logic             accept;
`ifndef SEQ_CMP_EARLY_EXIT_EN
    logic             decided;
    logic [1:0]       decided_verdict;
`endif

    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);

    // Zero-extend to a whole number of slices. In signed mode flipping the
    // sign bit maps two's complement onto offset binary, so every slice can
    // then be compared as unsigned.
    always_comb begin
        a_ext = EXT_W'(A);
        b_ext = EXT_W'(B);
        if (signed_mode) begin
            a_ext[WIDTH-1] = ~A[WIDTH-1];
            b_ext[WIDTH-1] = ~B[WIDTH-1];
        end
    end

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_op[i*CHUNK +: CHUNK];
                b_slice = b_op[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a       (a_slice),
        .b       (b_slice),
        .verdict (slice_verdict)
    );

    always_comb begin
        state_nxt     = state;
        finish        = 1'b0;
        final_verdict = slice_verdict;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if ((slice_verdict != CMP_EQ) || (idx == '0)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
`else
                // A higher slice already decided the outcome; lower slices
                // only run out the fixed latency.
                if (decided) begin
                    final_verdict = decided_verdict;
                end
                if (idx == '0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            done            <= 1'b0;
            A_gt_B          <= 1'b0;
            A_eq_B          <= 1'b0;
            A_lt_B          <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            decided         <= 1'b0;
            decided_verdict <= CMP_EQ;
`endif
        end else begin
            done <= finish;
            if (accept) begin
                idx     <= IDX_TOP;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                decided <= 1'b0;
`endif
            end else if (state == RUN) begin
                idx <= idx - 1'b1;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                if (!decided && (slice_verdict != CMP_EQ)) begin
                    decided         <= 1'b1;
                    decided_verdict <= slice_verdict;
                end
`endif
            end
            if (finish) begin
                A_gt_B <= (final_verdict == CMP_GT);
                A_eq_B <= (final_verdict == CMP_EQ);
                A_lt_B <= (final_verdict == CMP_LT);
            end
        end
    end

    // Operand slices are pure data; they are only meaningful once loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_op <= a_ext;
            b_op <= b_ext;
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comparator
// Directed bench for seq_mag_comparator (WIDTH=8, CHUNK=3). Each accepted
// request pushes its expected flags and latency to a queue; a monitor pops
// and compares on every done pulse. Honours SEQ_CMP_EARLY_EXIT_EN for the
// expected latency.
// -----------------------------------------------------------------------------
module tb_seq_mag_comparator;

    localparam int W  = 8;
    localparam int C  = 3;
    localparam int NC = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic         A_gt_B;
    logic         A_eq_B;
    logic         A_lt_B;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         edge_no;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] held = 3'b000;

    seq_mag_comparator #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .A_gt_B      (A_gt_B),
        .A_eq_B      (A_eq_B),
        .A_lt_B      (A_lt_B)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags are {gt, eq, lt}.
    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
        logic gt;
        logic lt;
        if (sm) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return {gt, (a == b), lt};
    endfunction

    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        for (int s = NC - 1; s >= 0; s--) begin
            for (int k = 0; k < C; k++) begin
                if ((s * C + k) < W && a[s*C+k] != b[s*C+k]) return NC - s;
            end
        end
`endif
        return NC;
    endfunction

    // Caller is at a negedge with the DUT idle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        exp_t e;
        check("idle_at_start", {31'd0, busy}, 32'd0);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        e.flags     = model_flags(a, b, sm);
        e.lat       = model_lat(a, b);
        e.edge_no   = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("flags", {29'd0, A_gt_B, A_eq_B, A_lt_B}, {29'd0, mon_e.flags});
                    check("latency", cyc - mon_e.edge_no, mon_e.lat);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    held = mon_e.flags;
                end
            end else if (busy) begin
                check("hold_while_busy", {29'd0, A_gt_B, A_eq_B, A_lt_B}, {29'd0, held});
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {29'd0, A_gt_B, A_eq_B, A_lt_B}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hAA, 8'h64, 1'b0); wait_drain(20); @(negedge clk);
        issue(8'd42, 8'd100, 1'b0); wait_drain(20); @(negedge clk);
        issue(8'd77, 8'd77, 1'b0); wait_drain(20); @(negedge clk);
        issue(8'h55, 8'h54, 1'b0); wait_drain(20); @(negedge clk);
        issue(8'hFF, 8'h01, 1'b1); wait_drain(20); @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0); wait_drain(20); @(negedge clk);
        issue(8'h80, 8'h7F, 1'b1); wait_drain(20); @(negedge clk);
        issue(8'h80, 8'h7F, 1'b0); wait_drain(20); @(negedge clk);

        // start while busy must be ignored
        issue(8'h4D, 8'h4D, 1'b0);
        A = 8'hFF; B = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", {31'd0, busy}, 32'd1);
        wait_drain(20);
        repeat (4) @(negedge clk);

        // back-to-back: new start in the done cycle
        issue(8'h55, 8'h54, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        issue(8'h10, 8'h20, 1'b0);
        wait_drain(20);
        @(negedge clk);

        // reset in the middle of a compare
        issue(8'h33, 8'h33, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_flags", {29'd0, A_gt_B, A_eq_B, A_lt_B}, 32'd0);
        q.delete();
        held = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        issue(8'hC3, 8'h3C, 1'b1); wait_drain(20); @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_drain(20);
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised, multi-cycle magnitude comparator. It is the sequential successor of the fixed 3-bit-slice, 8-bit combinational comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per clock, MSB slice first.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake.
- Serves datapath blocks that need wide compares without a long combinational chain.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CHUNK, 3, bits compared per cycle (1..WIDTH)
NUM_CHUNKS, ceil(WIDTH/CHUNK), derived localparam; not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
signed_mode  in  1  1 = two's-complement compare; sampled with start
A  in  WIDTH  operand A; sampled with start
B  in  WIDTH  operand B; sampled with start
busy  out  1  high while a compare is in progress
done  out  1  one-cycle pulse when a new result is valid
A_gt_B  out  1  registered result: A > B
A_eq_B  out  1  registered result: A == B
A_lt_B  out  1  registered result: A < B

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, A_gt_B, A_eq_B, A_lt_B all 0. Reset mid-compare aborts it; no done pulse.
- States:
  - IDLE -> RUN on start=1. Latch operands zero-extended at MSB to NUM_CHUNKS*CHUNK bits. If signed_mode=1, invert bit WIDTH-1 of both latched operands first (offset-binary), so the slice compare is unsigned. Set idx=NUM_CHUNKS-1 and busy=1.
  - RUN: each cycle compare slice idx of A against slice idx of B.
    - Slices differ: record gt or lt and go to IDLE.
    - Slices equal and idx=0: record eq and go to IDLE.
    - Otherwise: idx <= idx-1.
  - RUN -> IDLE: busy=0, done=1 for exactly one cycle. Result flags update on the same edge and are one-hot.
- Latency: done rises m edges after the edge that samples start. m = index of the first differing slice from the top plus 1, or NUM_CHUNKS if all slices are equal. Max latency is NUM_CHUNKS.
- Result outputs hold the last result until the next done; they do not change while busy.
- start while busy=1 is ignored, with no queueing.
- start in the cycle done=1 is accepted, since state is already IDLE, giving back-to-back compares.
- A, B and signed_mode changing during RUN have no effect.
- CHUNK=WIDTH gives a 1-cycle compare. CHUNK=1 gives a bit-serial compare.

Optional Feature:
Macro SEQ_CMP_EARLY_EXIT_EN.
- Defined: behaviour as above; RUN exits on the first differing slice (variable latency 1..NUM_CHUNKS).
- Undefined: RUN always visits all NUM_CHUNKS slices.
  - A sticky "decided" flag keeps the first differing slice's verdict; lower slices do not alter it.
  - done always arrives exactly NUM_CHUNKS edges after start, for deterministic latency.
  - Result values are identical to the defined case.

Decomposition:
- Package seq_cmp_pkg holds:
  - the state typedef (IDLE, RUN);
  - the 2-bit verdict encoding constants (CMP_EQ, CMP_GT, CMP_LT);
  - a num_chunks(width, chunk) ceiling function.
- One sub-module, cmp_chunk: a combinational CHUNK-bit slice comparator returning a verdict, instantiated once and fed by the idx mux.

Test Plan:
- Reset, then WIDTH=8, CHUNK=3, unsigned A=170 (0xAA), B=100 (0x64) -> top slices 010 vs 001; with EARLY_EXIT: done at edge 1, A_gt_B=1; without: done at edge 3, A_gt_B=1.
- A=42, B=100, unsigned -> A_lt_B=1, others 0; early exit at edge 1.
- A=B=77 -> A_eq_B=1 at edge 3 in both builds. Then A=0x55, B=0x54 -> differ only in the LSB slice, A_gt_B=1 at edge 3.
- A=0xFF, B=0x01: signed_mode=1 -> A_lt_B=1; signed_mode=0 -> A_gt_B=1. A=0x80, B=0x7F signed -> A_lt_B=1.
- Handshake:
  - Pulse start with new operands while busy -> ignored; the first result is unchanged.
  - Assert start in the done cycle -> second compare accepted; its done pulse is correct.
- Assert rst_n low mid-RUN -> busy, done and all flags 0 immediately. No spurious done after release. The next compare is correct.
